// File: rtl/bit_deser_pkg.sv
// Shared types and sizing helpers for the serial bit deserializer.
package bit_deser_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } deser_state_t;

  localparam int unsigned WORD_CNT_W = 8;

  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bit_triplet_deser.sv
// Serial-to-parallel collector: assembles WIDTH accepted bits into a word and
// holds one finished word on a registered valid/ready output.
module bit_triplet_deser
  import bit_deser_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_bit,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [WORD_CNT_W-1:0] word_cnt
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  deser_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] merged;
  logic             last_bit;
  logic             accept;
  logic             complete;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // Only the word-completing bit can stall, and only while a held word is blocked.
  assign in_ready = !flush && !(last_bit && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = accept && last_bit;

  always_comb begin
    merged = '0;
    if (MSB_FIRST != 0) merged = {partial[WIDTH-2:0], in_bit};
    else                merged = {in_bit, partial[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      cnt       <= '0;
      partial   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      word_cnt  <= '0;
    end else begin
      if (flush) begin
        cnt     <= '0;
        partial <= '0;
      end else if (accept) begin
        if (last_bit) begin
          cnt     <= '0;
          partial <= '0;
        end else begin
          cnt     <= cnt + 1'b1;
          partial <= merged;
        end
      end

      if (out_valid && out_ready) word_cnt <= word_cnt + 1'b1;

      // A completion while in HOLD implies out_ready=1, so replacing the word is a clean handoff.
      case (state)
        EMPTY: begin
          if (complete) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_data  <= merged;
          end
        end
        HOLD: begin
          if (complete) begin
            out_data <= merged;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_triplet_deser.sv
// Directed bench: table-driven vectors on a 3-bit MSB-first instance, plus
// reset and LSB-first/wrap sequences on a 4-bit instance.
module tb_bit_triplet_deser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_in_valid = 1'b0, a_in_bit = 1'b0, a_flush = 1'b0, a_out_ready = 1'b0;
  logic       a_in_ready, a_out_valid;
  logic [2:0] a_out_data;
  logic [7:0] a_word_cnt;

  logic       b_in_valid = 1'b0, b_in_bit = 1'b0, b_flush = 1'b0, b_out_ready = 1'b0;
  logic       b_in_ready, b_out_valid;
  logic [3:0] b_out_data;
  logic [7:0] b_word_cnt;

  bit_triplet_deser #(.WIDTH(3), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_bit(a_in_bit),
    .in_ready(a_in_ready), .flush(a_flush), .out_valid(a_out_valid),
    .out_data(a_out_data), .out_ready(a_out_ready), .word_cnt(a_word_cnt)
  );

  bit_triplet_deser #(.WIDTH(4), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_bit(b_in_bit),
    .in_ready(b_in_ready), .flush(b_flush), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_ready(b_out_ready), .word_cnt(b_word_cnt)
  );

  typedef struct {
    logic       v;
    logic       b;
    logic       fl;
    logic       rdy;
    logic       e_ird;
    logic       e_ov;
    logic [2:0] e_od;
    logic [7:0] e_wc;
  } vec_t;

  vec_t vec[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, b, fl, rdy, ird, ov, input logic [2:0] od, input logic [7:0] wc);
    vec_t r;
    r.v = v; r.b = b; r.fl = fl; r.rdy = rdy;
    r.e_ird = ird; r.e_ov = ov; r.e_od = od; r.e_wc = wc;
    vec.push_back(r);
  endtask

  task automatic step_a(input logic v, b, fl, rdy);
    a_in_valid = v; a_in_bit = b; a_flush = fl; a_out_ready = rdy;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] nib;

    //    v b f r | ird ov od      wc
    // basic word 101
    add(1,1,0,1, 1, 0, 3'b000, 0);
    add(1,0,0,1, 1, 0, 3'b000, 0);
    add(1,1,0,1, 1, 1, 3'b101, 0);
    add(0,0,0,1, 1, 0, 3'b101, 1);
    // back-to-back 101 110 011 000
    add(1,1,0,1, 1, 0, 3'b101, 1);
    add(1,0,0,1, 1, 0, 3'b101, 1);
    add(1,1,0,1, 1, 1, 3'b101, 1);
    add(1,1,0,1, 1, 0, 3'b101, 2);
    add(1,1,0,1, 1, 0, 3'b101, 2);
    add(1,0,0,1, 1, 1, 3'b110, 2);
    add(1,0,0,1, 1, 0, 3'b110, 3);
    add(1,1,0,1, 1, 0, 3'b110, 3);
    add(1,1,0,1, 1, 1, 3'b011, 3);
    add(1,0,0,1, 1, 0, 3'b011, 4);
    add(1,0,0,1, 1, 0, 3'b011, 4);
    add(1,0,0,1, 1, 1, 3'b000, 4);
    add(0,0,0,1, 1, 0, 3'b000, 5);
    // backpressure: hold 101, stall third bit of 111, release
    add(1,1,0,1, 1, 0, 3'b000, 5);
    add(1,0,0,1, 1, 0, 3'b000, 5);
    add(1,1,0,0, 1, 1, 3'b101, 5);
    add(1,1,0,0, 1, 1, 3'b101, 5);
    add(1,1,0,0, 1, 1, 3'b101, 5);
    add(1,1,0,0, 0, 1, 3'b101, 5);
    add(1,1,0,1, 1, 1, 3'b111, 6);
    add(0,0,0,0, 1, 1, 3'b111, 6);
    add(0,0,0,1, 1, 0, 3'b111, 7);
    // flush mid-word: 1,1 discarded, then 0,0,1
    add(1,1,0,1, 1, 0, 3'b111, 7);
    add(1,1,0,1, 1, 0, 3'b111, 7);
    add(1,1,1,1, 0, 0, 3'b111, 7);
    add(1,0,0,1, 1, 0, 3'b111, 7);
    add(1,0,0,1, 1, 0, 3'b111, 7);
    add(1,1,0,1, 1, 1, 3'b001, 7);
    add(0,0,0,1, 1, 0, 3'b001, 8);
    // flush while a word is held: the held word still drains
    add(1,1,0,0, 1, 0, 3'b001, 8);
    add(1,0,0,0, 1, 0, 3'b001, 8);
    add(1,1,0,0, 1, 1, 3'b101, 8);
    add(1,0,1,1, 0, 0, 3'b101, 9);
    // idle cycles keep the partial word
    add(1,1,0,1, 1, 0, 3'b101, 9);
    add(0,0,0,1, 1, 0, 3'b101, 9);
    add(0,1,0,1, 1, 0, 3'b101, 9);
    add(1,1,0,1, 1, 0, 3'b101, 9);
    add(1,0,0,1, 1, 1, 3'b110, 9);
    add(0,0,0,1, 1, 0, 3'b110, 10);

    // reset state
    #2;
    check("a_rst_ov", 32'(a_out_valid), 0);
    check("a_rst_od", 32'(a_out_data), 0);
    check("a_rst_wc", 32'(a_word_cnt), 0);
    check("b_rst_ov", 32'(b_out_valid), 0);
    check("b_rst_od", 32'(b_out_data), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("a_rst_ird", 32'(a_in_ready), 1);

    foreach (vec[i]) begin
      a_in_valid = vec[i].v; a_in_bit = vec[i].b; a_flush = vec[i].fl; a_out_ready = vec[i].rdy;
      #1;
      check($sformatf("vec%0d_ird", i), 32'(a_in_ready), 32'(vec[i].e_ird));
      @(posedge clk); #1;
      check($sformatf("vec%0d_ov", i), 32'(a_out_valid), 32'(vec[i].e_ov));
      check($sformatf("vec%0d_od", i), 32'(a_out_data), 32'(vec[i].e_od));
      check($sformatf("vec%0d_wc", i), 32'(a_word_cnt), 32'(vec[i].e_wc));
    end

    // asynchronous reset with a held word and two partial bits
    step_a(1,1,0,0); step_a(1,1,0,0); step_a(1,1,0,0);
    check("mr_held", 32'(a_out_data), 32'h7);
    step_a(1,0,0,0); step_a(1,1,0,0);
    a_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mr_ov", 32'(a_out_valid), 0);
    check("mr_od", 32'(a_out_data), 0);
    check("mr_wc", 32'(a_word_cnt), 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    step_a(1,0,0,1);
    check("mr_bit1_ov", 32'(a_out_valid), 0);
    step_a(1,1,0,1);
    check("mr_bit2_ov", 32'(a_out_valid), 0);
    step_a(1,0,0,1);
    check("mr_ov2", 32'(a_out_valid), 1);
    check("mr_od2", 32'(a_out_data), 32'h2);
    step_a(0,0,0,1);

    // LSB-first 4-bit: 256 continuous words, word_cnt wraps to 0
    b_out_ready = 1'b1;
    for (int unsigned w = 0; w < 256; w++) begin
      nib = (w == 0) ? 4'b0001 : 4'($urandom_range(0, 15));
      for (int unsigned k = 0; k < 4; k++) begin
        b_in_valid = 1'b1; b_in_bit = nib[k];
        #1;
        if (w < 4) check("b_ird", 32'(b_in_ready), 1);
        @(posedge clk); #1;
      end
      check("b_ov", 32'(b_out_valid), 1);
      check($sformatf("b_od%0d", w), 32'(b_out_data), 32'(nib));
      if (w == 255) check("b_wc255", 32'(b_word_cnt), 255);
    end
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    check("b_wrap_wc", 32'(b_word_cnt), 0);
    check("b_drain_ov", 32'(b_out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
